// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : Multi-cycle HI/LO execution unit. An iterative shift-add
//                multiplier serves mult/multu/madd/msub/mul. This block owns
//                the architectural HI/LO registers, serves mthi/mtlo/mfhi/mflo,
//                and raises a combinational Stall for HI/LO hazards.
//                Optional feature macro: MULDIV_DIV_EN adds div/divu through
//                a restoring divider.
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [5:0]       ALUCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             Stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(WIDTH + 2);

    localparam logic [5:0] OP_MULT  = 6'd4;
    localparam logic [5:0] OP_MULTU = 6'd24;
    localparam logic [5:0] OP_MADD  = 6'd16;
    localparam logic [5:0] OP_MSUB  = 6'd17;
    localparam logic [5:0] OP_MUL   = 6'd8;
    localparam logic [5:0] OP_MTHI  = 6'd30;
    localparam logic [5:0] OP_MTLO  = 6'd29;
    localparam logic [5:0] OP_MFHI  = 6'd31;
    localparam logic [5:0] OP_MFLO  = 6'd23;
`ifdef MULDIV_DIV_EN
    localparam logic [5:0] OP_DIV   = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd26;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;        // {upper partial, shifting operand}
    logic [WIDTH-1:0]     mcand_q, mcand_d;    // multiplicand or divisor magnitude
    logic [5:0]           op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;        // result must be negated at commit
`ifdef MULDIV_DIV_EN
    logic                 a_neg_q, a_neg_d;    // remainder follows dividend sign
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;    // raw dividend for divide-by-zero
    logic                 is_div, op_is_div;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_bit;
    logic [2*WIDTH-1:0]   div_next;
`endif

    logic                 is_mul, is_long, is_hilo, is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH+BITS_PER_CYCLE-1:0] mul_sum;
    logic [2*WIDTH-1:0]   mul_next, prod;

    // Decode the incoming op code into classes
    always_comb begin
        is_mul    = ALUCtrl inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL};
        is_long   = is_mul;
`ifdef MULDIV_DIV_EN
        is_div    = ALUCtrl inside {OP_DIV, OP_DIVU};
        is_long   = is_mul | is_div;
        op_is_div = op_q inside {OP_DIV, OP_DIVU};
`endif
        is_hilo   = is_long | (ALUCtrl inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
        is_signed = (ALUCtrl != OP_MULTU);
`ifdef MULDIV_DIV_EN
        is_signed = (ALUCtrl != OP_MULTU) && (ALUCtrl != OP_DIVU);
`endif
        // Unsigned magnitude: -2^(WIDTH-1) maps to 2^(WIDTH-1), still exact in WIDTH bits
        a_mag     = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        b_mag     = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    // One iteration of the shift-add multiplier and the restoring divider
    always_comb begin
        mul_sum  = {{BITS_PER_CYCLE{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}
                 + ({{BITS_PER_CYCLE{1'b0}}, mcand_q}
                    * {{WIDTH{1'b0}}, acc_q[BITS_PER_CYCLE-1:0]});
        mul_next = {mul_sum, acc_q[WIDTH-1:BITS_PER_CYCLE]};
        prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
`ifdef MULDIV_DIV_EN
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_bit   = (div_trial >= {1'b0, mcand_q});
        div_rem   = div_bit ? (div_trial[WIDTH-1:0] - mcand_q) : div_trial[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_bit};
`endif
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start && is_long) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0)      state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy whenever an op is in flight, stall HI/LO users on it
    always_comb begin
        Busy   = (state_q != S_IDLE);
        Stall  = Start & is_hilo & (Busy | is_long);
        Done   = done_q;
        Result = result_q;
        HI     = hi_q;
        LO     = lo_q;
    end

    // Datapath next values: launch, iterate, commit, and HI/LO moves
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
`ifdef MULDIV_DIV_EN
        a_neg_d  = a_neg_q;
        a_raw_d  = a_raw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start && is_long) begin
                    op_d    = ALUCtrl;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    mcand_d = b_mag;
                    neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    cnt_d   = CNT_W'(N - 1);
`ifdef MULDIV_DIV_EN
                    if (is_div) cnt_d = CNT_W'(WIDTH - 1);
                    a_neg_d = is_signed & A[WIDTH-1];
                    a_raw_d = A;
`endif
                end else if (Start) begin
                    case (ALUCtrl)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        OP_MFHI: begin result_d = hi_q; done_d = 1'b1; end
                        OP_MFLO: begin result_d = lo_q; done_d = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = mul_next;
`ifdef MULDIV_DIV_EN
                if (op_is_div) acc_d = div_next;
`endif
            end
            S_FIN: begin
                case (op_q)
                    OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                    OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod;
                    OP_MUL: begin
                        result_d = prod[WIDTH-1:0];
                        done_d   = 1'b1;
                    end
`ifdef MULDIV_DIV_EN
                    OP_DIV, OP_DIVU: begin
                        if (mcand_q == '0) begin
                            lo_d = '1;
                            hi_d = a_raw_q;
                        end else begin
                            lo_d = neg_q   ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                            hi_d = a_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                           : acc_q[2*WIDTH-1:WIDTH];
                        end
                    end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any op in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            a_neg_q  <= 1'b0;
            a_raw_q  <= '0;
`endif
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
`ifdef MULDIV_DIV_EN
            a_neg_q  <= a_neg_d;
            a_raw_q  <= a_raw_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_unit
//  Description : Self-checking bench for hilo_muldiv_unit with a 64-bit
//                arithmetic reference model of HI/LO and Result.
//                Optional feature macro: MULDIV_DIV_EN enables divide checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;

    localparam logic [5:0] C_MULT  = 6'd4;
    localparam logic [5:0] C_MULTU = 6'd24;
    localparam logic [5:0] C_MADD  = 6'd16;
    localparam logic [5:0] C_MSUB  = 6'd17;
    localparam logic [5:0] C_MUL   = 6'd8;
    localparam logic [5:0] C_MTHI  = 6'd30;
    localparam logic [5:0] C_MTLO  = 6'd29;
    localparam logic [5:0] C_MFHI  = 6'd31;
    localparam logic [5:0] C_MFLO  = 6'd23;
    localparam logic [5:0] C_DIV   = 6'd25;
    localparam logic [5:0] C_DIVU  = 6'd26;
    localparam int         C_BUSY  = 33;

    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [5:0]  ALUCtrl;
    logic [31:0] A, B;
    logic [31:0] Result, HI, LO;
    logic        Done, Busy, Stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi, m_lo;

    hilo_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
        .A(A), .B(B), .Result(Result), .Done(Done), .Busy(Busy),
        .Stall(Stall), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; ALUCtrl = '0; A = '0; B = '0;
        step(); step();
        Reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        checks++; if (HI !== 32'h0)     begin errors++; $display("FAIL reset_hi got %h exp 0", HI); end
        checks++; if (LO !== 32'h0)     begin errors++; $display("FAIL reset_lo got %h exp 0", LO); end
        checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", Result); end
        checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", Done); end
        checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b exp 0", Stall); end
    endtask

    // mthi / mtlo: takes effect at the next edge, never stalls
    task automatic move_to(input logic [5:0] code, input logic [31:0] v);
        Start = 1'b1; ALUCtrl = code; A = v; B = $urandom;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL move_to_stall got %b exp 0", Stall); end
        step();
        Start = 1'b0; ALUCtrl = '0;
        if (code == C_MTHI) m_hi = v; else m_lo = v;
        checks++; if ({HI, LO} !== {m_hi, m_lo})
            begin errors++; $display("FAIL move_to_hilo got %h_%h exp %h_%h", HI, LO, m_hi, m_lo); end
    endtask

    // mfhi / mflo: one-cycle Done pulse carrying the model's register value
    task automatic move_from(input logic [5:0] code);
        logic [31:0] exp;
        exp = (code == C_MFHI) ? m_hi : m_lo;
        Start = 1'b1; ALUCtrl = code; A = $urandom; B = $urandom;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL move_from_stall got %b exp 0", Stall); end
        step();
        Start = 1'b0; ALUCtrl = '0;
        checks++; if (Done !== 1'b1)  begin errors++; $display("FAIL move_from_done got %b exp 1", Done); end
        checks++; if (Result !== exp) begin errors++; $display("FAIL move_from_result got %h exp %h", Result, exp); end
        step();
        checks++; if (Done !== 1'b0)  begin errors++; $display("FAIL move_from_pulse got %b exp 0", Done); end
    endtask

    // Reference results computed with plain 64-bit arithmetic
    task automatic model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic [31:0] er);
        longint      sa, sb;
        logic [63:0] ps, pu, ua, ub, q, r;
        sa = $signed(a); sb = $signed(b);
        ua = {32'h0, a}; ub = {32'h0, b};
        ps = sa * sb;
        pu = ua * ub;
        eh = m_hi; el = m_lo; er = 'x;
        case (code)
            C_MULT:  {eh, el} = ps;
            C_MULTU: {eh, el} = pu;
            C_MADD:  {eh, el} = {m_hi, m_lo} + ps;
            C_MSUB:  {eh, el} = {m_hi, m_lo} - ps;
            C_MUL:   er = ps[31:0];
            C_DIV, C_DIVU: begin
                if (b == 32'h0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else begin
                    q = (code == C_DIV) ? sa / sb : ua / ub;
                    r = (code == C_DIV) ? sa % sb : ua % ub;
                    el = q[31:0]; eh = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Launch a multi-cycle op; optionally hold a HI/LO read behind it
    task automatic long_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] rd);
        logic [31:0] eh, el, er;
        int          cyc;
        bit          stall_ok, done_ok;
        model(code, a, b, eh, el, er);
        Start = 1'b1; ALUCtrl = code; A = a; B = b;
        #1;
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL op_issue_stall got %b exp 1", Stall); end
        step();
        if (rd != 6'd0) begin ALUCtrl = rd; A = $urandom; end
        else begin Start = 1'b0; ALUCtrl = '0; end
        #1;
        cyc = 0; stall_ok = 1; done_ok = 1;
        while (Busy === 1'b1 && cyc < 200) begin
            if (rd != 6'd0 && Stall !== 1'b1) stall_ok = 0;
            if (Done !== 1'b0) done_ok = 0;
            cyc++;
            step();
        end
        checks++; if (cyc != C_BUSY) begin errors++; $display("FAIL op_busy_cycles got %0d exp %0d", cyc, C_BUSY); end
        checks++; if (!done_ok) begin errors++; $display("FAIL op_done_while_busy got 1 exp 0"); end
        if (rd != 6'd0) begin
            checks++; if (!stall_ok) begin errors++; $display("FAIL hazard_stall got 0 exp 1"); end
        end
        checks++; if ({HI, LO} !== {eh, el})
            begin errors++; $display("FAIL op_hilo code %0d got %h_%h exp %h_%h", code, HI, LO, eh, el); end
        m_hi = eh; m_lo = el;
        if (code == C_MUL) begin
            checks++; if (Done !== 1'b1) begin errors++; $display("FAIL mul_done got %b exp 1", Done); end
            checks++; if (Result !== er) begin errors++; $display("FAIL mul_result got %h exp %h", Result, er); end
        end else begin
            checks++; if (Done !== 1'b0) begin errors++; $display("FAIL op_done got %b exp 0", Done); end
        end
        if (rd != 6'd0) begin
            checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL hazard_release got %b exp 0", Stall); end
            step();
            Start = 1'b0; ALUCtrl = '0;
            checks++; if (Done !== 1'b1) begin errors++; $display("FAIL hazard_done got %b exp 1", Done); end
            checks++; if (Result !== ((rd == C_MFHI) ? m_hi : m_lo))
                begin errors++; $display("FAIL hazard_result got %h exp %h", Result, (rd == C_MFHI) ? m_hi : m_lo); end
        end
        step();
    endtask

    task automatic test_moves();
        move_to(C_MTHI, 32'h0000_1234);
        move_from(C_MFHI);
        move_to(C_MTLO, $urandom);
        move_from(C_MFLO);
        move_to(C_MTHI, $urandom);
        move_from(C_MFHI);
    endtask

    task automatic test_directed();
        long_op(C_MULT, 32'hFFFF_FFFD, 32'd7, C_MFLO);
        long_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0);
        long_op(C_MADD, 32'd1, 32'd1, 6'd0);
        long_op(C_MSUB, 32'd2, 32'd1, C_MFHI);
        long_op(C_MUL, 32'd6, 32'hFFFF_FFF9, 6'd0);
        long_op(C_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0);
    endtask

    task automatic test_reset_abort();
        int cyc;
        Start = 1'b1; ALUCtrl = C_MULT; A = 32'd5; B = 32'd5;
        step();
        Start = 1'b0; ALUCtrl = '0;
        for (cyc = 0; cyc < 10; cyc++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        m_hi = '0; m_lo = '0;
        checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL abort_hilo got %h_%h exp 0_0", HI, LO); end
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b exp 0", Busy); end
        long_op(C_MULT, 32'd2, 32'd3, C_MFLO);
    endtask

    task automatic test_ignored(input logic [5:0] code);
        Start = 1'b1; ALUCtrl = code; A = $urandom; B = $urandom;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL ignored_stall got %b exp 0", Stall); end
        step();
        Start = 1'b0; ALUCtrl = '0;
        checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("FAIL ignored_busy_done got %b exp 00", {Busy, Done}); end
        checks++; if ({HI, LO} !== {m_hi, m_lo})
            begin errors++; $display("FAIL ignored_hilo got %h_%h exp %h_%h", HI, LO, m_hi, m_lo); end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    task automatic test_random(input int iters);
        logic [5:0] codes [5];
        logic [5:0] code, rd;
        codes[0] = C_MULT; codes[1] = C_MULTU; codes[2] = C_MADD;
        codes[3] = C_MSUB; codes[4] = C_MUL;
        for (int i = 0; i < iters; i++) begin
            code = codes[$urandom_range(4)];
            rd   = 6'd0;
            if (code != C_MUL && $urandom_range(1) == 1) rd = $urandom_range(1) ? C_MFHI : C_MFLO;
            long_op(code, pick_operand(), pick_operand(), rd);
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_divide();
        long_op(C_DIV, 32'hFFFF_FFF9, 32'd2, C_MFHI);
        long_op(C_DIVU, 32'd9, 32'd0, 6'd0);
        long_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0);
        for (int i = 0; i < 8; i++)
            long_op($urandom_range(1) ? C_DIV : C_DIVU, pick_operand(), pick_operand(), 6'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_moves();
        test_directed();
        test_reset_abort();
        test_ignored(6'd5);
`ifdef MULDIV_DIV_EN
        test_divide();
`else
        test_ignored(C_DIV);
        test_ignored(C_DIVU);
`endif
        test_random(24);
        move_from(C_MFHI);
        move_from(C_MFLO);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
